// File: rtl/sys_resp_pkg.sv
// Shared types and constants for the UART response receiver.
// FSM state encoding, legal oversampling ratios and their fallback.
package sys_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [5:0] PRESC_8   = 6'd8;
  localparam logic [5:0] PRESC_16  = 6'd16;
  localparam logic [5:0] PRESC_32  = 6'd32;
  localparam logic [5:0] PRESC_DEF = PRESC_16;

  // Anything but 8/16/32 falls back to the default ratio.
  function automatic logic [5:0] legal_presc(
    input logic [5:0] p
  );
    case (p)
      PRESC_8, PRESC_16, PRESC_32: return p;
      default:                     return PRESC_DEF;
    endcase
  endfunction

endpackage

// File: rtl/sys_resp_bit_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority vote.
// Ports: clk, rst_n, ser_in, presc, run -> ser_sync, bit_done, bit_val, bit_end.
module sys_resp_bit_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic [5:0] presc,
  input  logic       run,
  output logic       ser_sync,
  output logic       bit_done,
  output logic       bit_val,
  output logic       bit_end
);

  logic [1:0] sync_q;
  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic       s0;
  logic       s1;

  assign half     = presc >> 1;
  assign ser_sync = sync_q[1];
  assign bit_done = run && (edge_cnt == half + 6'd1);
  assign bit_end  = run && (edge_cnt == presc - 6'd1);
  // Third vote is the live sample at the decision point.
  assign bit_val  = (s0 & s1) | (s0 & ser_sync) | (s1 & ser_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      edge_cnt <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ser_in};
      if (!run || bit_end)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + 6'd1;
      if (run && edge_cnt == half - 6'd1)
        s0 <= ser_sync;
      if (run && edge_cnt == half)
        s1 <= ser_sync;
    end
  end

endmodule

// File: rtl/sys_resp_rx.sv
// Host-side UART response receiver: 1- or 2-byte responses with error flags.
// Ports: CLK, RST, SER_IN, config, ARM/EXPECT_LEN -> RESP_*, *_ERR, TIMEOUT, BUSY.
module sys_resp_rx
  import sys_resp_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      SER_IN,
  input  logic [5:0]                PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      ARM,
  input  logic                      EXPECT_LEN,
  input  logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_LIMIT,
  output logic [2*DATA_WIDTH-1:0]   RESP_DATA,
  output logic                      RESP_VALID,
  output logic                      PAR_ERR,
  output logic                      STOP_ERR,
  output logic                      TIMEOUT,
  output logic                      BUSY
);

  localparam int BW = $clog2(DATA_WIDTH);

  state_t                   state;
  logic [5:0]               presc_q;
  logic                     par_en_q;
  logic                     par_typ_q;
  logic                     len_q;
  logic                     byte_idx;
  logic [DATA_WIDTH-1:0]    shreg;
  logic [BW-1:0]            bit_cnt;
  logic                     par_bad;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [TIMEOUT_WIDTH-1:0] tmo_nxt;
  logic                     run;
  logic                     ser_sync;
  logic                     bit_done;
  logic                     bit_val;
  logic                     bit_end;
  logic                     tmo_hit;

  assign run = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign tmo_nxt = tmo_cnt + 1'b1;
  // A glitch in START keeps counting, so the check is >= not ==.
  assign tmo_hit = (TIMEOUT_LIMIT != '0) && (tmo_nxt >= TIMEOUT_LIMIT);

  sys_resp_bit_sampler u_sampler (
    .clk      (CLK),
    .rst_n    (RST),
    .ser_in   (SER_IN),
    .presc    (presc_q),
    .run      (run),
    .ser_sync (ser_sync),
    .bit_done (bit_done),
    .bit_val  (bit_val),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      len_q      <= 1'b0;
      byte_idx   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bad    <= 1'b0;
      tmo_cnt    <= '0;
      RESP_DATA  <= '0;
      RESP_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
      TIMEOUT    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      RESP_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
      TIMEOUT    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ARM) begin
            presc_q   <= legal_presc(PRESCALE);
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            len_q     <= EXPECT_LEN;
            byte_idx  <= 1'b0;
            par_bad   <= 1'b0;
            tmo_cnt   <= '0;
            RESP_DATA <= '0;
            BUSY      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_nxt;
          if (!ser_sync) begin
            par_bad <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_START;
          end else if (tmo_hit) begin
            TIMEOUT <= 1'b1;
            BUSY    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_START: begin
          tmo_cnt <= tmo_nxt;
          if (bit_done && bit_val)
            state <= ST_WAIT;
          else if (bit_end)
            state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_done)
            shreg[bit_cnt] <= bit_val;
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_WIDTH - 1))
              state <= par_en_q ? ST_PARITY : ST_STOP;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_done)
            par_bad <= bit_val != ((^shreg) ^ par_typ_q);
          if (bit_end)
            state <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_done) begin
            if (!bit_val) begin
              STOP_ERR <= 1'b1;
              BUSY     <= 1'b0;
              state    <= ST_IDLE;
            end else if (par_bad) begin
              PAR_ERR <= 1'b1;
              BUSY    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              if (byte_idx)
                RESP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= shreg;
              else
                RESP_DATA[DATA_WIDTH-1:0] <= shreg;
              if (byte_idx == len_q) begin
                RESP_VALID <= 1'b1;
                BUSY       <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                byte_idx <= 1'b1;
                tmo_cnt  <= '0;
                state    <= ST_WAIT;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_resp_rx.sv
// Scoreboard bench for sys_resp_rx with a frame-level reference model.
// Stimulus pushes expected outcomes; a negedge monitor pops and compares.
module tb_sys_resp_rx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SER_IN = 1'b1;
  logic [5:0]  PRESCALE = 6'd16;
  logic        PAR_EN = 1'b0;
  logic        PAR_TYP = 1'b0;
  logic        ARM = 1'b0;
  logic        EXPECT_LEN = 1'b0;
  logic [15:0] TIMEOUT_LIMIT = 16'd0;
  logic [15:0] RESP_DATA;
  logic        RESP_VALID;
  logic        PAR_ERR;
  logic        STOP_ERR;
  logic        TIMEOUT;
  logic        BUSY;

  always #5 CLK = ~CLK;

  sys_resp_rx #(
    .DATA_WIDTH    (8),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SER_IN        (SER_IN),
    .PRESCALE      (PRESCALE),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .ARM           (ARM),
    .EXPECT_LEN    (EXPECT_LEN),
    .TIMEOUT_LIMIT (TIMEOUT_LIMIT),
    .RESP_DATA     (RESP_DATA),
    .RESP_VALID    (RESP_VALID),
    .PAR_ERR       (PAR_ERR),
    .STOP_ERR      (STOP_ERR),
    .TIMEOUT       (TIMEOUT),
    .BUSY          (BUSY)
  );

  localparam logic [3:0] K_VALID = 4'b1000;
  localparam logic [3:0] K_PERR  = 4'b0100;
  localparam logic [3:0] K_SERR  = 4'b0010;
  localparam logic [3:0] K_TMO   = 4'b0001;

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] data;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  fails  = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [3:0] got;
    ev_t        e;
    got = {RESP_VALID, PAR_ERR, STOP_ERR, TIMEOUT};
    if (got != 4'b0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {28'd0, got}, 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {28'd0, got}, {28'd0, e.kind});
        if (e.kind == K_VALID)
          check("resp_data", {16'd0, RESP_DATA}, {16'd0, e.data});
      end
    end
  end

  // Outcome of one armed transaction, decided byte by byte.
  function automatic ev_t model(bit pe, bit pt, bit len,
                                logic [15:0] dd, logic [1:0] pb,
                                logic [1:0] sb, output int ns);
    ev_t e;
    e.kind = K_VALID;
    e.data = 16'd0;
    ns = len ? 2 : 1;
    for (int b = 0; b < ns; b++) begin
      logic [7:0] d;
      d = dd[8*b +: 8];
      if (!sb[b]) begin
        e.kind = K_SERR;
        e.data = 16'd0;
        ns = b + 1;
        return e;
      end
      if (pe && (pb[b] != ((^d) ^ pt))) begin
        e.kind = K_PERR;
        e.data = 16'd0;
        ns = b + 1;
        return e;
      end
      e.data[8*b +: 8] = d;
    end
    return e;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic arm(int p, bit pe, bit pt, bit len, int lim);
    PRESCALE = 6'(p);
    PAR_EN = pe;
    PAR_TYP = pt;
    EXPECT_LEN = len;
    TIMEOUT_LIMIT = 16'(lim);
    ARM = 1'b1;
    tick(1);
    ARM = 1'b0;
  endtask

  task automatic send_bit(bit v, int p);
    SER_IN = v;
    tick(p);
  endtask

  task automatic send_frame(logic [7:0] d, int p, bit pe,
                            bit pbit, bit sbit);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++)
      send_bit(d[i], p);
    if (pe)
      send_bit(pbit, p);
    send_bit(sbit, p);
    SER_IN = 1'b1;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (BUSY && n < 1000) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic run_txn(int p_arm, int p_line, bit pe, bit pt,
                         bit len, logic [15:0] dd, logic [1:0] pb,
                         logic [1:0] sb, int gap);
    ev_t e;
    int  ns;
    e = model(pe, pt, len, dd, pb, sb, ns);
    q.push_back(e);
    arm(p_arm, pe, pt, len, 0);
    tick(gap);
    for (int b = 0; b < ns; b++) begin
      send_frame(dd[8*b +: 8], p_line, pe, pb[b], sb[b]);
      if (b + 1 < ns) begin
        check("busy_between", {31'd0, BUSY}, 32'd1);
        tick(gap);
      end
    end
    wait_idle("busy_end");
    tick(4);
  endtask

  task automatic timeout_test(bit glitch);
    int first;
    first = -1;
    q.push_back('{kind: K_TMO, data: 16'd0});
    arm(16, 0, 0, 0, 100);
    for (int k = 1; k <= 150; k++) begin
      tick(1);
      if (glitch && k == 20) SER_IN = 1'b0;
      if (glitch && k == 22) SER_IN = 1'b1;
      if (k == 99)
        check("busy_before_tmo", {31'd0, BUSY}, 32'd1);
      if (TIMEOUT && first < 0) first = k;
    end
    check("timeout_cycle", first, 100);
    check("busy_after_tmo", {31'd0, BUSY}, 32'd0);
    TIMEOUT_LIMIT = 16'd0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tick(3);
    check("reset_outputs",
          {11'd0, RESP_DATA, RESP_VALID, PAR_ERR, STOP_ERR, TIMEOUT, BUSY},
          32'd0);
    RST = 1'b1;
    tick(3);

    run_txn(8, 8, 1, 0, 0, 16'h00A5, 2'b00, 2'b11, 3);
    run_txn(16, 16, 0, 0, 1, 16'h1234, 2'b00, 2'b11, 5);
    run_txn(32, 32, 1, 1, 0, 16'h000F, 2'b00, 2'b11, 2);
    run_txn(16, 16, 1, 0, 0, 16'h003C, 2'b01, 2'b10, 2);
    run_txn(16, 16, 1, 0, 0, 16'h0055, 2'b00, 2'b11, 2);
    run_txn(12, 16, 0, 0, 0, 16'h0099, 2'b00, 2'b11, 2);

    timeout_test(1'b0);
    tick(4);
    timeout_test(1'b1);
    tick(4);

    q.push_back('{kind: K_VALID, data: 16'h003C});
    arm(16, 0, 0, 0, 0);
    tick(300);
    check("busy_no_limit", {31'd0, BUSY}, 32'd1);
    send_frame(8'h3C, 16, 0, 0, 1);
    wait_idle("busy_no_limit_end");
    tick(4);

    q.push_back('{kind: K_VALID, data: 16'h0077});
    arm(16, 0, 0, 0, 0);
    tick(5);
    EXPECT_LEN = 1'b1;
    PRESCALE = 6'd8;
    ARM = 1'b1;
    tick(1);
    ARM = 1'b0;
    send_frame(8'h77, 16, 0, 0, 1);
    wait_idle("busy_arm_ignored");
    tick(4);

    arm(16, 0, 0, 0, 0);
    tick(2);
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++)
      send_bit(i[0] ? 1'b1 : 1'b1 & (i < 2), 16);
    tick(8);
    check("busy_mid_frame", {31'd0, BUSY}, 32'd1);
    RST = 1'b0;
    #1;
    check("reset_mid_frame",
          {11'd0, RESP_DATA, RESP_VALID, PAR_ERR, STOP_ERR, TIMEOUT, BUSY},
          32'd0);
    SER_IN = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(3);
    run_txn(16, 16, 0, 0, 0, 16'h00C3, 2'b00, 2'b11, 2);

    for (int n = 0; n < 30; n++) begin
      int          p;
      bit          pe;
      bit          pt;
      bit          len;
      logic [15:0] dd;
      logic [1:0]  pb;
      logic [1:0]  sb;
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      len = 1'($urandom);
      dd  = 16'($urandom);
      for (int b = 0; b < 2; b++) begin
        logic [7:0] d;
        d = dd[8*b +: 8];
        pb[b] = (^d) ^ pt ^ ($urandom_range(0, 5) == 0);
        sb[b] = ($urandom_range(0, 7) != 0);
      end
      run_txn(p, p, pe, pt, len, dd, pb, sb, $urandom_range(0, 20));
    end

    tick(10);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/sys_resp_rx.md
Name: sys_resp_rx

Overview:
- Response receiver on the serial output of the system top (its TX_OUT) in the UART_CLK domain.
- Oversamples the line and deserializes UART frames: start bit, 8 data bits LSB first, optional parity, stop bit.
- Assembles 1-byte (RegFile read) or 2-byte (ALU result, low byte first) responses into one word and flags framing errors and timeouts.
- Used as the host-side response stage in system benches and in loopback self-test.

Parameters:
- DATA_WIDTH, 8, bits per UART frame.
- TIMEOUT_WIDTH, 16, width of the response timeout counter.

Ports:
- CLK  in  1  oversampling clock (UART_CLK).
- RST  in  1  asynchronous active-low reset.
- SER_IN  in  1  serial line; idles high.
- PRESCALE  in  6  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- ARM  in  1  one-cycle pulse that starts waiting for a response.
- EXPECT_LEN  in  1  0 = 1-byte response, 1 = 2-byte response; sampled on ARM.
- TIMEOUT_LIMIT  in  TIMEOUT_WIDTH  CLK cycles allowed between ARM or a byte end and the next start bit.
- RESP_DATA  out  2*DATA_WIDTH  assembled response; upper byte 0 for 1-byte responses.
- RESP_VALID  out  1  one-cycle pulse; RESP_DATA is valid in that cycle.
- PAR_ERR  out  1  one-cycle pulse on a parity mismatch.
- STOP_ERR  out  1  one-cycle pulse when the stop bit is sampled low.
- TIMEOUT  out  1  one-cycle pulse on timeout.
- BUSY  out  1  high from ARM until the response completes, errors or times out.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0. SER_IN is held in a 2-flop synchronizer; all sampling uses the synchronized value.
- ARM handling:
  - ARM in IDLE latches PRESCALE, PAR_EN, PAR_TYP and EXPECT_LEN, clears the assembly register and enters WAIT. BUSY rises the next cycle.
  - ARM while BUSY is ignored.
  - A PRESCALE value other than 8, 16 or 32 is latched as 16.
- FSM states: IDLE, WAIT, START, DATA, PARITY, STOP.
- Timing counters:
  - edge_cnt runs 0..P-1 within each bit, where P is the latched prescale; bit_cnt counts 0..7.
  - Sample points are edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, decided at edge_cnt = P/2+1.
- WAIT:
  - Synchronized SER_IN = 0 enters START with edge_cnt = 0.
  - The timeout counter increments each cycle. When it reaches TIMEOUT_LIMIT: TIMEOUT pulses, BUSY falls, FSM returns to IDLE.
  - TIMEOUT_LIMIT = 0 disables the timeout.
- START: a majority of 1 is a glitch; return to WAIT without resetting the timeout counter. At edge_cnt = P-1, enter DATA.
- DATA: shift the majority bit into position bit_cnt (LSB first). After bit 7 completes, enter PARITY if PAR_EN, else STOP.
- PARITY: compare the majority bit with the XOR of the data bits, inverted when PAR_TYP = 1. A mismatch sets an internal par_bad flag; the FSM still proceeds to STOP.
- STOP: at the decision sample (edge_cnt = P/2+1):
  - Majority 0: STOP_ERR pulses next cycle.
  - Else, par_bad set: PAR_ERR pulses next cycle.
  - Either error aborts: BUSY falls, FSM returns to IDLE, RESP_VALID is not asserted.
  - Good byte:
    - The byte is written to RESP_DATA[7:0] for byte 0 or to [15:8] for byte 1.
    - If this is the last expected byte, RESP_VALID pulses and BUSY falls in the next cycle, and the FSM returns to IDLE.
    - Otherwise the FSM returns to WAIT with the timeout counter cleared.
  - The remainder of the stop bit is not waited for.
- Priority when both errors hit the same byte: STOP_ERR wins; only one error pulse is issued.
- Line activity in IDLE is ignored.
- RESP_DATA holds its value until the next ARM.
- Latency: RESP_VALID occurs 3 CLK cycles after the stop-bit midpoint on the pin (2 synchronizer stages plus 1 output register).
- Reset asserted mid-frame returns everything to reset values immediately (asynchronous). No pulse is emitted.

Decomposition:
- Shared package sys_resp_pkg: FSM state encoding, prescale constants 8/16/32, default prescale 16.
- One sub-module, sys_resp_bit_sampler: contains the synchronizer, edge_cnt and the 3-sample majority vote. It outputs bit_done and bit_val.
- The top level holds the FSM, data shift register, parity check, byte assembly and timeout counter.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, EXPECT_LEN=0; send 0xA5 with parity 0 -> RESP_DATA=0x00A5, one RESP_VALID pulse, BUSY low afterwards.
- PRESCALE=16, parity off, EXPECT_LEN=1; send 0x34 then 0x12 -> RESP_DATA=0x1234, exactly one RESP_VALID, after the second frame only.
- PRESCALE=32, PAR_EN=1, PAR_TYP=1; send 0x0F with parity bit 0 (correct value is 1) -> PAR_ERR pulse, no RESP_VALID, FSM in IDLE.
- Send a frame with stop bit 0 and also a wrong parity bit -> STOP_ERR only, no PAR_ERR; then ARM again and a good 0x55 -> 0x0055 valid.
- TIMEOUT_LIMIT=100, ARM, line idle -> TIMEOUT pulse exactly 100 cycles after ARM; a 2-cycle low glitch during WAIT does not start a frame.
- Assert RST during bit 4 of a frame -> all outputs 0; after release, ARM plus a 0xC3 frame -> 0x00C3 valid. Also: ARM pulsed while BUSY -> no effect on the latched EXPECT_LEN.
